// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrowin one bit per clock, LSB
// first, and publishes diff/borrowout on completion with a one-cycle done.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowout
);

  // Counter must be able to hold WIDTH itself: it counts processed bits and
  // the terminal value WIDTH marks the hand-off cycle into DONE.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic a_bit, b_bit, d_bit, br_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: start only matters in IDLE; RUN ends once all bits are in
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Full-subtractor on the current LSBs of the operand shift registers
  always_comb begin
    a_bit  = a_sh_q[0];
    b_bit  = b_sh_q[0];
    d_bit  = a_bit ^ b_bit ^ br_q;
    br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  end

  // Datapath next values: capture in IDLE, shift in RUN, publish at the end
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    res_d  = res_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d = a;
          b_sh_d = b;
          br_d   = borrowin;
          res_d  = '0;
          cnt_d  = '0;
        end
      end
      RUN: begin
        if (cnt_q != LAST) begin
          a_sh_d = a_sh_q >> 1;
          b_sh_d = b_sh_q >> 1;
          // new result bit enters at the MSB so bit 0 lands at bit 0 after WIDTH shifts
          res_d  = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
          br_d   = br_nxt;
          cnt_d  = cnt_q + CW'(1);
        end else begin
          diff_d = res_q;
          bout_d = br_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; outputs only change on the RUN-to-DONE edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      res_q  <= res_d;
      br_q   <= br_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end

  assign diff      = diff_q;
  assign borrowout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       st8 = 1'b0, st1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bi8 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       bi1 = 1'b0;
  logic       bsy8, dn8, bo8, bsy1, dn1, bo1;
  logic [7:0] df8;
  logic [0:0] df1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .borrowin(bi8),
    .busy(bsy8), .done(dn8), .diff(df8), .borrowout(bo8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .borrowin(bi1),
    .busy(bsy1), .done(dn1), .diff(df1), .borrowout(bo1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One transaction on either DUT; disturb keeps start high and scrambles
  // a/b on the 8-bit DUT for the whole run.
  task automatic do_op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                       input logic bi, input logic [7:0] ed, input logic eb,
                       input bit disturb, input int exp_lat);
    int n;
    int extra;
    bit got;
    @(negedge clk);
    if (w1) begin a1 = a[0:0]; b1 = b[0:0]; bi1 = bi; st1 = 1'b1; end
    else    begin a8 = a;      b8 = b;      bi8 = bi; st8 = 1'b1; end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (disturb) begin st8 = 1'b1; a8 = ~a; b8 = a; end
      else begin st8 = 1'b0; st1 = 1'b0; end
      if (n == 1) chk("busy_on", {31'd0, w1 ? bsy1 : bsy8}, 32'd1);
      got = w1 ? dn1 : dn8;
    end
    st8 = 1'b0;
    st1 = 1'b0;
    chk("latency", n, exp_lat);
    chk("diff", w1 ? {31'd0, df1} : {24'd0, df8}, {24'd0, ed});
    chk("bout", {31'd0, w1 ? bo1 : bo8}, {31'd0, eb});
    chk("busy_done", {31'd0, w1 ? bsy1 : bsy8}, 32'd0);
    extra = 0;
    repeat (11) begin
      @(posedge clk);
      @(negedge clk);
      if (w1 ? dn1 : dn8) extra++;
    end
    chk("one_done", extra, 0);
    chk("diff_hold", w1 ? {31'd0, df1} : {24'd0, df8}, {24'd0, ed});
  endtask

  logic [15:0] tbl1;
  logic [2:0]  v;
  int          late_done;

  initial begin
    // Reset with start held high: nothing may be accepted
    a8 = 8'd3; b8 = 8'd1; st8 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; st1 = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, bsy8}, 32'd0);
    chk("rst_done", {31'd0, dn8}, 32'd0);
    chk("rst_diff", {24'd0, df8}, 32'd0);
    chk("rst_bout", {31'd0, bo8}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_busy", {31'd0, bsy8}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("first_accept", {31'd0, bsy8}, 32'd1);
    st8 = 1'b0;
    st1 = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_diff", {24'd0, df8}, 32'd2);
    chk("post_rst_w1", {30'd0, df1, bo1}, 32'd0);

    // Main WIDTH=8 vectors
    do_op(1'b0, 8'd100, 8'd58, 1'b0, 8'd42,  1'b0, 1'b0, 10);
    do_op(1'b0, 8'd5,   8'd7,  1'b0, 8'hFE,  1'b1, 1'b0, 10);
    do_op(1'b0, 8'd0,   8'd0,  1'b1, 8'hFF,  1'b1, 1'b0, 10);
    do_op(1'b0, 8'hFF,  8'hFF, 1'b1, 8'hFF,  1'b1, 1'b0, 10);
    do_op(1'b0, 8'h80,  8'h01, 1'b0, 8'h7F,  1'b0, 1'b0, 10);
    // Start and operand changes during RUN must be ignored
    do_op(1'b0, 8'h30,  8'h10, 1'b0, 8'h20,  1'b0, 1'b1, 10);

    // Reset in the middle of a run
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd58; bi8 = 1'b0; st8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, bsy8}, 32'd0);
    chk("mid_rst_diff", {24'd0, df8}, 32'd0);
    chk("mid_rst_bout", {31'd0, bo8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    late_done = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (dn8) late_done++;
    end
    chk("no_done_after_abort", late_done, 0);
    do_op(1'b0, 8'd9, 8'd4, 1'b0, 8'd5, 1'b0, 1'b0, 10);

    // WIDTH=1 truth table, (a,b,borrowin) = 000..111 -> {diff,borrowout}
    tbl1 = {2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      do_op(1'b1, {7'd0, v[2]}, {7'd0, v[1]}, v[0],
            {7'd0, tbl1[(7-i)*2+1]}, tbl1[(7-i)*2], 1'b0, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 1 to 32).
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
REQ-005 Port: a  input  WIDTH  minuend; captured when start is accepted.
REQ-006 Port: b  input  WIDTH  subtrahend; captured when start is accepted.
REQ-007 Port: borrowin  input  1  initial borrow into bit 0; captured when start is accepted.
REQ-008 Port: busy  output  1  high while a subtraction is in progress.
REQ-009 Port: done  output  1  one-cycle pulse marking a completed result.
REQ-010 Port: diff  output  WIDTH  result a - b - borrowin, modulo 2^WIDTH.
REQ-011 Port: borrowout  output  1  borrow out of bit WIDTH-1; high means a < b + borrowin.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 SHALL latch a, b and borrowin into internal shift and borrow registers, clear the bit counter and move to RUN.
REQ-014 start SHALL be ignored in RUN and DONE; captured operands SHALL NOT change during a run.
REQ-015 In RUN, each clock SHALL process one bit, LSB first, using the full-subtractor equations:
  - d = a_i XOR b_i XOR br
  - br_next = (NOT a_i AND b_i) OR (NOT (a_i XOR b_i) AND br)
REQ-016 In RUN, each clock SHALL shift d into the internal result register from the MSB side and shift the operand registers right by one.
REQ-017 After exactly WIDTH RUN cycles, the FSM SHALL move to DONE.
REQ-018 On the RUN-to-DONE edge, diff SHALL load the full result and borrowout SHALL load the final borrow.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH+1; minimum start-to-start spacing is WIDTH+2 cycles.
REQ-021 busy SHALL equal 1 exactly while the FSM is in RUN.
REQ-022 diff and borrowout SHALL hold their last values until the next completion, with no intermediate partial results visible.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within a run.
REQ-024 With WIDTH=1, results SHALL match the single-bit full-subtractor truth table exactly.

Reset
REQ-025 On rst=1, regardless of clk, the block SHALL immediately force:
  - FSM to IDLE
  - busy=0, done=0, diff=0, borrowout=0
  - all internal operand, borrow and counter registers to 0
REQ-026 Reset asserted mid-RUN SHALL abort the run with no done pulse; stimulus presented after reset SHALL be accepted normally.
REQ-027 start held high during reset SHALL have no effect; start SHALL first be accepted on the first rising edge of clk after rst deasserts.

Verification (WIDTH=8 unless stated)
REQ-028 a=100, b=58, borrowin=0, start pulse -> done after 10 cycles, diff=42, borrowout=0.
REQ-029 a=5, b=7, borrowin=0 -> diff=0xFE, borrowout=1; then a=0, b=0, borrowin=1 -> diff=0xFF, borrowout=1.
REQ-030 a=0xFF, b=0xFF, borrowin=1 -> diff=0xFF, borrowout=1; a=0x80, b=0x01, borrowin=0 -> diff=0x7F, borrowout=0.
REQ-031 Second start pulse and changed a/b during RUN -> ignored; first result unchanged; exactly one done pulse.
REQ-032 rst pulse at cycle 3 of RUN -> immediate busy=0, diff=0, no done; new start with a=9, b=4 -> diff=5, borrowout=0.
REQ-033 WIDTH=1, all 8 (a, b, borrowin) combinations -> diff/borrowout = 00, 11, 11, 01, 10, 00, 00, 11 in order 000..111.
